lieat_sram64_arb_ctrl: RTL and testbench

Two-requester arbiter and sequencer for one single-port 64-entry x 64-bit register-array SRAM (write enable, 6-bit address, 64-bit write data, combinational read data on the addressed entry). After reset, and on demand, it walks every entry and writes INIT_VALUE. In normal operation it round-robins at most one read or write per cycle between two valid/ready request ports and returns registered read data. It sits between VPU-side clients (e.g. a vector-lane writer and a reader) and the storage array.

---
 rtl/lieat_sram64_arb_ctrl_pkg.sv | 14 +
 rtl/lieat_sram64_arb_ctrl_if.sv | 36 +++
 rtl/lieat_sram64_arb_ctrl_rr_arb2.sv | 44 ++++
 rtl/lieat_sram64_arb_ctrl.sv | 127 ++++++++++++
 tb/tb_lieat_sram64_arb_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/lieat_sram64_arb_ctrl_pkg.sv
// Shared definitions for the 64x64 SRAM arbiter/sequencer: FSM encoding and
// array geometry.
package lieat_sram64_arb_ctrl_pkg;

    localparam int SRAM_AW    = 6;
    localparam int SRAM_DW    = 64;
    localparam int SRAM_DEPTH = 64;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

endpackage

// File: rtl/lieat_sram64_arb_ctrl_if.sv
// Two request/response client ports of the SRAM arbiter. The master modport is
// the client side and the slave modport is the controller side.
interface lieat_sram64_arb_ctrl_if;
    import lieat_sram64_arb_ctrl_pkg::*;

    logic               req0_valid;
    logic               req0_ready;
    logic               req0_we;
    logic [SRAM_AW-1:0] req0_addr;
    logic [SRAM_DW-1:0] req0_wdata;
    logic               rsp0_valid;
    logic [SRAM_DW-1:0] rsp0_rdata;

    logic               req1_valid;
    logic               req1_ready;
    logic               req1_we;
    logic [SRAM_AW-1:0] req1_addr;
    logic [SRAM_DW-1:0] req1_wdata;
    logic               rsp1_valid;
    logic [SRAM_DW-1:0] rsp1_rdata;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata
    );

endinterface

// File: rtl/lieat_sram64_arb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter with a one-hot grant. The pointer remembers the
// last granted port and only moves when a grant is issued.
module lieat_rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    // Grant selection and pointer update.
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end else begin
            gnt = 2'b00;
        end
        if (gnt != 2'b00) begin
            last_d = gnt[1];
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register; "last=1" out of reset so port 0 wins the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/lieat_sram64_arb_ctrl.sv
// Arbiter and sequencer for a single-port 64x64 register-array SRAM: sweeps
// INIT_VALUE into every entry, then serves two round-robin request ports.
module lieat_sram64_arb_ctrl
    import lieat_sram64_arb_ctrl_pkg::*;
#(
    parameter logic [SRAM_DW-1:0] INIT_VALUE = 64'h0,
    parameter int                 DEPTH_LOG2 = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clr,
    output logic                  init_busy,
    lieat_sram64_arb_ctrl_if.slave bus,
    output logic                  sram_wen,
    output logic [DEPTH_LOG2-1:0] sram_a,
    output logic [SRAM_DW-1:0]    sram_d,
    input  logic [SRAM_DW-1:0]    sram_q
);

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic [SRAM_DW-1:0]    rsp0_rdata_q, rsp0_rdata_d;
    logic [SRAM_DW-1:0]    rsp1_rdata_q, rsp1_rdata_d;

    logic                  arb_en_s;
    logic [1:0]            gnt_s;

    // clr wins over any pending request, so arbitration is masked that cycle.
    assign arb_en_s = (state_q == ST_IDLE) && !clr;

    lieat_rr_arb2 u_arb (
        .clock (clock),
        .reset (reset),
        .req   ({bus.req1_valid, bus.req0_valid}),
        .en    (arb_en_s),
        .gnt   (gnt_s)
    );

    // Next-state, sweep counter, SRAM drive and response capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sram_wen     = 1'b0;
        sram_a       = '0;
        sram_d       = '0;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;

        case (state_q)
            ST_INIT: begin
                sram_wen = 1'b1;
                sram_a   = cnt_q;
                sram_d   = INIT_VALUE;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == {DEPTH_LOG2{1'b1}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else if (gnt_s[0]) begin
                    sram_wen     = bus.req0_we;
                    sram_a       = bus.req0_addr;
                    sram_d       = bus.req0_we ? bus.req0_wdata : '0;
                    rsp0_valid_d = !bus.req0_we;
                    if (!bus.req0_we) begin
                        rsp0_rdata_d = sram_q;
                    end else begin
                        rsp0_rdata_d = rsp0_rdata_q;
                    end
                end else if (gnt_s[1]) begin
                    sram_wen     = bus.req1_we;
                    sram_a       = bus.req1_addr;
                    sram_d       = bus.req1_we ? bus.req1_wdata : '0;
                    rsp1_valid_d = !bus.req1_we;
                    if (!bus.req1_we) begin
                        rsp1_rdata_d = sram_q;
                    end else begin
                        rsp1_rdata_d = rsp1_rdata_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and response registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign init_busy      = (state_q == ST_INIT);
    assign bus.req0_ready = gnt_s[0];
    assign bus.req1_ready = gnt_s[1];
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_lieat_sram64_arb_ctrl.sv
// Directed bench for lieat_sram64_arb_ctrl with a behavioural 64x64 SRAM.
module tb_lieat_sram64_arb_ctrl;
    import lieat_sram64_arb_ctrl_pkg::*;

    logic        clock;
    logic        reset;
    logic        clr;
    logic        init_busy;
    logic        sram_wen;
    logic [5:0]  sram_a;
    logic [63:0] sram_d;
    logic [63:0] sram_q;
    logic [63:0] mem [64];

    int n_checks;
    int n_errors;

    lieat_sram64_arb_ctrl_if bus ();

    lieat_sram64_arb_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .clr       (clr),
        .init_busy (init_busy),
        .bus       (bus.slave),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural SRAM, pre-filled with non-zero junk so the sweep is visible.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    end
    always @(posedge clock) begin
        if (sram_wen) mem[sram_a] <= sram_d;
    end
    assign sram_q = mem[sram_a];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic we, input logic [5:0] a, input logic [63:0] wd);
        bus.req0_valid = v;
        bus.req0_we    = we;
        bus.req0_addr  = a;
        bus.req0_wdata = wd;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [5:0] a, input logic [63:0] wd);
        bus.req1_valid = v;
        bus.req1_we    = we;
        bus.req1_addr  = a;
        bus.req1_wdata = wd;
    endtask

    // Checks n sweep cycles from the current counter 0 position; ends one cycle later.
    task automatic sweep(input int start, input int n);
        for (int i = start; i < start + n; i++) begin
            check_val($sformatf("sweep%0d", i),
                      {57'd0, init_busy, sram_wen, sram_a},
                      {57'd0, 1'b1, 1'b1, 6'(i)});
            check_val($sformatf("sweep_rdy%0d", i),
                      {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
            @(negedge clock);
            #1;
        end
    endtask

    // Expected grant/response table for the both-valid read sequence.
    logic [1:0] exp_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [1:0] exp_rsp [4] = '{2'b00, 2'b10, 2'b01, 2'b10};

    initial begin
        n_checks = 0;
        n_errors = 0;
        clr      = 1'b0;
        reset    = 1'b1;
        drive0(1'b1, 1'b0, 6'd63, 64'd0);
        drive1(1'b1, 1'b0, 6'd62, 64'd0);
        #1 reset = 1'b0;

        // Reset values with requests pending.
        @(negedge clock);
        #1;
        check_val("rst_busy", {63'd0, init_busy}, 64'd1);
        check_val("rst_rdy", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
        check_val("rst_rspv", {62'd0, bus.rsp0_valid, bus.rsp1_valid}, 64'd0);
        check_val("rst_rd0", bus.rsp0_rdata, 64'd0);
        check_val("rst_rd1", bus.rsp1_rdata, 64'd0);
        check_val("rst_sram", {57'd0, sram_wen, sram_a}, {57'd0, 1'b1, 6'd0});

        // Full sweep after release, requests held throughout.
        reset = 1'b1;
        sweep(0, 64);
        check_val("idle_busy", {63'd0, init_busy}, 64'd0);
        check_val("first_grant", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd2);
        check_val("first_sram", {57'd0, sram_wen, sram_a}, {57'd0, 1'b0, 6'd63});
        @(negedge clock);
        drive0(1'b0, 1'b0, 6'd0, 64'd0);
        drive1(1'b0, 1'b0, 6'd0, 64'd0);
        #1;
        check_val("rd63_v", {62'd0, bus.rsp0_valid, bus.rsp1_valid}, 64'd2);
        check_val("rd63_d", bus.rsp0_rdata, 64'd0);
        check_val("nogrant_sram", {sram_wen, sram_a, sram_d[56:0]}, 64'd0);

        // Write then read-after-write on port 0.
        @(negedge clock);
        drive0(1'b1, 1'b1, 6'd5, 64'hDEAD_BEEF_0000_0005);
        #1;
        check_val("wr5_rdy", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd2);
        check_val("wr5_sram", {57'd0, sram_wen, sram_a}, {57'd0, 1'b1, 6'd5});
        check_val("wr5_d", sram_d, 64'hDEAD_BEEF_0000_0005);
        @(negedge clock);
        drive0(1'b1, 1'b0, 6'd5, 64'd0);
        #1;
        check_val("rd5_sram", {57'd0, sram_wen, sram_a}, {57'd0, 1'b0, 6'd5});
        check_val("wr5_norsp", {62'd0, bus.rsp0_valid, bus.rsp1_valid}, 64'd0);
        @(negedge clock);
        drive0(1'b0, 1'b0, 6'd0, 64'd0);
        #1;
        check_val("rd5_v", {62'd0, bus.rsp0_valid, bus.rsp1_valid}, 64'd2);
        check_val("rd5_d", bus.rsp0_rdata, 64'hDEAD_BEEF_0000_0005);
        @(negedge clock);
        #1;
        check_val("rd5_pulse", {62'd0, bus.rsp0_valid, bus.rsp1_valid}, 64'd0);
        check_val("rd5_hold", bus.rsp0_rdata, 64'hDEAD_BEEF_0000_0005);

        // Seed addr 2 from port 0 and addr 1 from port 1, leaving pointer at last=1.
        @(negedge clock);
        drive0(1'b1, 1'b1, 6'd2, 64'h2222);
        @(negedge clock);
        drive0(1'b0, 1'b0, 6'd0, 64'd0);
        drive1(1'b1, 1'b1, 6'd1, 64'h1111);
        #1;
        check_val("wr1_p1", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd1);

        // Both ports reading: grants alternate 0,1,0,1.
        @(negedge clock);
        drive0(1'b1, 1'b0, 6'd1, 64'd0);
        drive1(1'b1, 1'b0, 6'd2, 64'd0);
        for (int c = 0; c < 4; c++) begin
            #1;
            check_val($sformatf("alt_rdy%0d", c), {62'd0, bus.req0_ready, bus.req1_ready}, {62'd0, exp_rdy[c]});
            check_val($sformatf("alt_rsp%0d", c), {62'd0, bus.rsp0_valid, bus.rsp1_valid}, {62'd0, exp_rsp[c]});
            if (c > 0 && bus.rsp0_valid) check_val($sformatf("alt_d0_%0d", c), bus.rsp0_rdata, 64'h1111);
            if (c > 0 && bus.rsp1_valid) check_val($sformatf("alt_d1_%0d", c), bus.rsp1_rdata, 64'h2222);
            @(negedge clock);
        end
        drive0(1'b0, 1'b0, 6'd0, 64'd0);
        drive1(1'b0, 1'b0, 6'd0, 64'd0);
        #1;
        check_val("alt_last", {62'd0, bus.rsp0_valid, bus.rsp1_valid}, 64'd1);
        check_val("alt_last_d", bus.rsp1_rdata, 64'h2222);

        // Write addr 10, then clr together with a port 1 read: clr wins.
        @(negedge clock);
        drive0(1'b1, 1'b1, 6'd10, 64'h1234);
        @(negedge clock);
        drive0(1'b0, 1'b0, 6'd0, 64'd0);
        drive1(1'b1, 1'b0, 6'd10, 64'd0);
        clr = 1'b1;
        #1;
        check_val("clr_rdy", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
        check_val("clr_sram", {57'd0, sram_wen, sram_a}, 64'd0);
        @(negedge clock);
        clr = 1'b0;
        #1;
        sweep(0, 30);
        clr = 1'b1;
        sweep(30, 1);
        clr = 1'b0;
        sweep(31, 33);
        check_val("clr_grant", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd1);
        check_val("clr_rd10_a", {57'd0, sram_wen, sram_a}, {57'd0, 1'b0, 6'd10});
        @(negedge clock);
        drive1(1'b0, 1'b0, 6'd0, 64'd0);
        #1;
        check_val("clr_rd10_v", {62'd0, bus.rsp0_valid, bus.rsp1_valid}, 64'd1);
        check_val("clr_rd10_d", bus.rsp1_rdata, 64'd0);

        // Reset in the middle of a read: response dropped, data cleared.
        @(negedge clock);
        drive0(1'b1, 1'b0, 6'd5, 64'd0);
        #1;
        check_val("mr_rdy", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd2);
        #2 reset = 1'b0;
        #1;
        check_val("mr_rst_rdy", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
        check_val("mr_rst_busy", {57'd0, init_busy, sram_wen, sram_a}, {57'd0, 1'b1, 1'b1, 6'd0});
        check_val("mr_rst_rd0", bus.rsp0_rdata, 64'd0);
        check_val("mr_rst_rd1", bus.rsp1_rdata, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        drive0(1'b0, 1'b0, 6'd0, 64'd0);
        #1;
        check_val("mr_norsp", {62'd0, bus.rsp0_valid, bus.rsp1_valid}, 64'd0);

        // Reset mid-sweep at counter 20, then the sweep restarts from 0.
        sweep(0, 20);
        reset = 1'b0;
        #1;
        check_val("ms_rst", {57'd0, init_busy, sram_wen, sram_a}, {57'd0, 1'b1, 1'b1, 6'd0});
        @(negedge clock);
        reset = 1'b1;
        #1;
        sweep(0, 64);
        check_val("ms_done", {63'd0, init_busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global guard against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
